// File: rtl/key_search.sv
// Reverse lookup over a small key/data table: given a data value, sequentially
// scan the entries and return the key and index of the lowest matching valid entry.
module key_search #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2,
  localparam int IDX_W   = (NR_KEY > 2) ? $clog2(NR_KEY) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_hit,
  output logic [KEY_LEN-1:0]  rsp_key,
  output logic [IDX_W-1:0]    rsp_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [NR_KEY-1:0]   valid_r;
  logic [KEY_LEN-1:0]  key_r  [NR_KEY];
  logic [DATA_LEN-1:0] data_r [NR_KEY];
  logic [DATA_LEN-1:0] req_data_r;
  logic [IDX_W-1:0]    scan_idx_r;
  logic                hit_r;
  logic [KEY_LEN-1:0]  key_out_r;
  logic [IDX_W-1:0]    idx_out_r;
  logic                match_s;
  logic                last_s;
  logic                write_s;

  // Compare the single entry selected by the scan index.
  always_comb begin
    match_s = valid_r[scan_idx_r] && (data_r[scan_idx_r] == req_data_r);
    last_s  = (scan_idx_r == IDX_W'(NR_KEY - 1));
    write_s = (state_r == IDLE) && wr_en && !clr;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // FSM next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_s = SCAN;
        else           state_s = IDLE;
      end
      SCAN: begin
        if (match_s || last_s) state_s = RESP;
        else                   state_s = SCAN;
      end
      RESP: begin
        if (rsp_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Request latch, scan index and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_data_r <= '0;
      scan_idx_r <= '0;
      hit_r      <= 1'b0;
      key_out_r  <= '0;
      idx_out_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            req_data_r <= req_data;
            scan_idx_r <= '0;
          end
        end
        SCAN: begin
          if (match_s) begin
            hit_r     <= 1'b1;
            key_out_r <= key_r[scan_idx_r];
            idx_out_r <= scan_idx_r;
          end else if (last_s) begin
            hit_r     <= 1'b0;
            key_out_r <= '0;
            idx_out_r <= '0;
          end else begin
            scan_idx_r <= scan_idx_r + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Valid bits: clear beats write; both only take effect while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
    end else if (state_r == IDLE && clr) begin
      valid_r <= '0;
    end else begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (write_s && wr_idx == IDX_W'(i)) valid_r[i] <= 1'b1;
      end
    end
  end

  // Key/data payload; out-of-range indices match no entry and are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NR_KEY; i++) begin
      if (write_s && wr_idx == IDX_W'(i)) begin
        key_r[i]  <= wr_key;
        data_r[i] <= wr_data;
      end
    end
  end

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = (state_r == RESP);
  assign rsp_hit   = hit_r;
  assign rsp_key   = key_out_r;
  assign rsp_idx   = idx_out_r;

endmodule

// File: tb/tb_key_search.sv
// Directed plus randomized bench for key_search against a table-level reference model.
module tb_key_search;

  localparam int NR = 4;
  localparam int KL = 2;
  localparam int DL = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic [KL-1:0] wr_key = '0;
  logic [DL-1:0] wr_data = '0;
  logic          clr = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DL-1:0] req_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_hit;
  logic [KL-1:0] rsp_key;
  logic [IW-1:0] rsp_idx;

  int passed = 0;
  int total  = 0;

  bit            m_valid [NR];
  logic [KL-1:0] m_key   [NR];
  logic [DL-1:0] m_data  [NR];

  key_search #(.NR_KEY(NR), .KEY_LEN(KL), .DATA_LEN(DL)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit), .rsp_key(rsp_key), .rsp_idx(rsp_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_write(input int idx, input logic [KL-1:0] k, input logic [DL-1:0] d);
    if (idx < NR) begin
      m_valid[idx] = 1'b1;
      m_key[idx]   = k;
      m_data[idx]  = d;
    end
  endtask

  task automatic m_clear();
    for (int e = 0; e < NR; e++) m_valid[e] = 1'b0;
  endtask

  // Lowest valid entry holding d wins; hit at entry e takes e+1 cycles, a miss NR.
  task automatic m_find(input logic [DL-1:0] d, output bit hit, output logic [KL-1:0] k,
                        output logic [IW-1:0] i, output int lat);
    hit = 1'b0; k = '0; i = '0; lat = NR;
    for (int e = NR - 1; e >= 0; e--) begin
      if (m_valid[e] && m_data[e] == d) begin
        hit = 1'b1; k = m_key[e]; i = IW'(e); lat = e + 1;
      end
    end
  endtask

  task automatic write_entry(input int idx, input logic [KL-1:0] k, input logic [DL-1:0] d);
    wr_en = 1'b1; wr_idx = IW'(idx); wr_key = k; wr_data = d;
    tick();
    wr_en = 1'b0;
    m_write(idx, k, d);
  endtask

  task automatic clear_tbl(input bit also_write);
    clr = 1'b1; wr_en = also_write; wr_idx = '0; wr_key = 2'b11; wr_data = 2'b10;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    m_clear();
  endtask

  task automatic search(input string tag, input logic [DL-1:0] d, input bit cw,
                        input int wi, input logic [KL-1:0] wk, input logic [DL-1:0] wd,
                        input int hold, input bit junk);
    bit eh; logic [KL-1:0] ek; logic [IW-1:0] ei; int el; int lat;
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    if (cw) m_write(wi, wk, wd);
    m_find(d, eh, ek, ei, el);
    req_valid = 1'b1; req_data = d;
    wr_en = cw; wr_idx = IW'(wi); wr_key = wk; wr_data = wd;
    tick();
    req_valid = 1'b0; wr_en = 1'b0;
    if (junk) begin
      wr_en = 1'b1; wr_idx = '0; wr_key = ~ek; wr_data = d;
    end
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < NR + 4) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(el));
    check({tag, ".hit"}, 32'(rsp_hit), 32'(eh));
    check({tag, ".key"}, 32'(rsp_key), 32'(ek));
    check({tag, ".idx"}, 32'(rsp_idx), 32'(ei));
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
      check({tag, ".hold_hit"}, 32'(rsp_hit), 32'(eh));
      check({tag, ".hold_key"}, 32'(rsp_key), 32'(ek));
      check({tag, ".hold_idx"}, 32'(rsp_idx), 32'(ei));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; wr_en = 1'b0;
    check({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    m_clear();
    tick();
    tick();
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.rsp_hit", 32'(rsp_hit), 32'd0);
    check("reset.rsp_key", 32'(rsp_key), 32'd0);
    check("reset.rsp_idx", 32'(rsp_idx), 32'd0);
    rst = 1'b0;
    #1;
    check("reset.req_ready", 32'(req_ready), 32'd1);

    // Basic table and lookups.
    write_entry(0, 2'b00, 2'd1);
    write_entry(1, 2'b01, 2'd3);
    write_entry(2, 2'b10, 2'd0);
    write_entry(3, 2'b11, 2'd2);
    search("d0", 2'd0, 1'b0, 0, '0, '0, 0, 1'b0);
    check("d0.key_const", 32'(rsp_key), 32'd2);
    search("d1", 2'd1, 1'b0, 0, '0, '0, 0, 1'b0);
    clear_tbl(1'b0);
    search("d1_cleared", 2'd1, 1'b0, 0, '0, '0, 0, 1'b0);

    // Duplicate data, held response and ignored writes during SCAN/RESP.
    write_entry(0, 2'b00, 2'd0);
    write_entry(1, 2'b01, 2'd3);
    write_entry(2, 2'b10, 2'd1);
    write_entry(3, 2'b11, 2'd3);
    search("dup", 2'd3, 1'b0, 0, '0, '0, 5, 1'b1);
    search("dup_after_junk", 2'd3, 1'b0, 0, '0, '0, 0, 1'b0);
    check("dup.idx_const", 32'(rsp_idx), 32'd1);

    // Reset during SCAN: no response, table empty afterward.
    req_valid = 1'b1; req_data = 2'd2;
    tick();
    req_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_scan.rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    m_clear();
    #1;
    check("rst_scan.req_ready", 32'(req_ready), 32'd1);
    for (int v = 0; v < 4; v++) search("after_rst", DL'(v), 1'b0, 0, '0, '0, 0, 1'b0);

    // Reset while a hit response is pending.
    write_entry(0, 2'b10, 2'd1);
    req_valid = 1'b1; req_data = 2'd1;
    tick();
    req_valid = 1'b0;
    tick();
    check("rst_resp.valid_before", 32'(rsp_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_resp.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_resp.rsp_hit", 32'(rsp_hit), 32'd0);
    check("rst_resp.rsp_key", 32'(rsp_key), 32'd0);
    tick();
    rst = 1'b0;
    m_clear();
    #1;

    // Write merged with accept; clr beats a simultaneous write.
    search("wr_accept", 2'd2, 1'b1, 0, 2'b01, 2'd2, 0, 1'b0);
    write_entry(1, 2'b11, 2'd1);
    clear_tbl(1'b1);
    search("clr_wins", 2'd2, 1'b0, 0, '0, '0, 0, 1'b0);
    search("clr_wins1", 2'd1, 1'b0, 0, '0, '0, 0, 1'b0);

    // Randomized mix against the reference model.
    for (int n = 0; n < 120; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        write_entry($urandom_range(0, NR - 1), KL'($urandom), DL'($urandom));
      end else if (op == 4) begin
        clear_tbl(1'($urandom));
      end else begin
        search("rand", DL'($urandom), 1'($urandom), $urandom_range(0, NR - 1),
               KL'($urandom), DL'($urandom), $urandom_range(0, 3), 1'($urandom));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/key_search.md
KEY_SEARCH -- requirements
Module: key_search

Interface
REQ-001 Parameter NR_KEY, default 4: number of table entries, 2..256.
REQ-002 Parameter KEY_LEN, default 2: key width in bits.
REQ-003 Parameter DATA_LEN, default 2: data width in bits; IDX_W = max(1, clog2(NR_KEY)).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 wr_en  input  1  table write strobe.
REQ-007 wr_idx  input  IDX_W  entry index to write.
REQ-008 wr_key  input  KEY_LEN  key stored at wr_idx.
REQ-009 wr_data  input  DATA_LEN  data stored at wr_idx.
REQ-010 clr  input  1  invalidate all entries.
REQ-011 req_valid  input  1  search request present.
REQ-012 req_ready  output  1  block can accept a request.
REQ-013 req_data  input  DATA_LEN  data value to look up.
REQ-014 rsp_valid  output  1  result present.
REQ-015 rsp_ready  input  1  consumer accepts result.
REQ-016 rsp_hit  output  1  1 = match found.
REQ-017 rsp_key  output  KEY_LEN  key of the matching entry; 0 on miss.
REQ-018 rsp_idx  output  IDX_W  index of the matching entry; 0 on miss.

Function
REQ-019 Function: inverse of the key-to-data mux table; given data, return the key of the lowest-index valid entry whose data equals req_data.
REQ-020 Storage: NR_KEY registered entries {valid, key, data}.
REQ-021 FSM states: IDLE, SCAN, RESP.
REQ-022 req_ready = 1 only in IDLE.
REQ-023 In IDLE, req_valid=1 at an edge: the request is accepted, req_data is latched, scan index = 0, and the next state is SCAN.
REQ-024 In SCAN, exactly one entry (scan index) is compared per cycle.
REQ-025 Entry valid and data equal: at the next edge, register hit=1, key and idx, and go to RESP.
REQ-026 No match and index = NR_KEY-1: at the next edge, register hit=0, key=0, idx=0, and go to RESP.
REQ-027 Otherwise: increment the index and remain in SCAN.
REQ-028 Latency: a hit at index i raises rsp_valid i+1 cycles after the accept edge; a miss raises it NR_KEY cycles after.
REQ-029 rsp_valid = 1 only in RESP; rsp_hit, rsp_key and rsp_idx are held stable while rsp_valid=1 and rsp_ready=0.
REQ-030 In RESP, rsp_ready=1 at an edge returns the FSM to IDLE; the next request is accepted no earlier than the following edge (no back-to-back bypass).
REQ-031 Writes: wr_en is honored only in IDLE; at the edge, the entry at wr_idx is set to {1, wr_key, wr_data}.
REQ-032 wr_en in SCAN or RESP is ignored and the table is unchanged.
REQ-033 wr_idx >= NR_KEY is ignored.
REQ-034 clr is honored only in IDLE and clears all valid bits at the edge.
REQ-035 clr together with wr_en: clr wins and no entry is written.
REQ-036 Write together with request acceptance in IDLE: the write takes effect at the same edge, so the scan sees the new entry.
REQ-037 Duplicate data values in the table: the lowest index wins.
REQ-038 Invalid entries never match, regardless of their data contents.

Reset
REQ-039 rst=1 asynchronously forces state IDLE, all valid bits 0, scan index 0, rsp_valid 0, rsp_hit 0, rsp_key 0, rsp_idx 0; req_ready=1 once rst deasserts.
REQ-040 Stored key/data fields need not be reset; they are unobservable while their valid bit is 0.
REQ-041 rst asserted mid-SCAN or in RESP aborts the operation with no response, and the table is empty afterward.

Verification (NR_KEY=4, KEY_LEN=2, DATA_LEN=2)
REQ-042 Write entries {00,d1},{01,d3},{10,d0},{11,d2}, search d0 -> rsp_hit=1, key=10, idx=2, and rsp_valid 3 cycles after accept.
REQ-043 Search d1 -> hit, key=00, idx=0, latency 1 cycle; after clr, search d1 -> rsp_hit=0, key=0, latency 4 cycles.
REQ-044 Entries 1 and 3 both hold data 2'b11, search 11 -> idx=1 (lowest index wins).
REQ-045 Hold rsp_ready=0 for 5 cycles -> outputs stable and req_ready=0 throughout; a wr_en during SCAN/RESP leaves the table unchanged (confirmed by a later search).
REQ-046 Assert rst during SCAN -> rsp_valid=0 immediately; a subsequent search of any value misses.
REQ-047 wr_en and req_valid in the same IDLE cycle, writing {01,d2} to idx 0 and searching d2 -> hit, key=01, idx=0.
